// File: rtl/calc_pkg.sv
// Shared definitions for the calculator: default width, opcodes and the
// one-hot state encoding that is also presented on the Q output.
package calc_pkg;

    localparam int DEFAULT_WIDTH = 16;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    // Bit positions inside the one-hot state vector (MSB is INITIAL)
    localparam int Q_INITIAL_BIT = 9;
    localparam int Q_GET_A_BIT   = 8;
    localparam int Q_GET_B_BIT   = 7;
    localparam int Q_GET_OP_BIT  = 6;
    localparam int Q_ADD_BIT     = 5;
    localparam int Q_SUB_BIT     = 4;
    localparam int Q_MUL_BIT     = 3;
    localparam int Q_DIV_BIT     = 2;
    localparam int Q_ERR_BIT     = 1;
    localparam int Q_DONE_BIT    = 0;

    typedef enum logic [9:0] {
        ST_INITIAL = 10'b10_0000_0000,
        ST_GET_A   = 10'b01_0000_0000,
        ST_GET_B   = 10'b00_1000_0000,
        ST_GET_OP  = 10'b00_0100_0000,
        ST_ADD     = 10'b00_0010_0000,
        ST_SUB     = 10'b00_0001_0000,
        ST_MUL     = 10'b00_0000_1000,
        ST_DIV     = 10'b00_0000_0100,
        ST_ERR     = 10'b00_0000_0010,
        ST_DONE    = 10'b00_0000_0001
    } state_t;

endpackage

// File: rtl/calc_iter_unit.sv
// Iterative WIDTH-step engine shared by multiply (right-shift shift-add)
// and divide (restoring). The first step is taken on the start edge using
// the incoming operands, so the result is ready WIDTH-1 edges later and
// o_done is high during the WIDTH-th cycle after start.
module calc_iter_unit
    import calc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_done
);

    localparam int CW = $clog2(WIDTH + 1);

    // hi: product high half / partial remainder
    // lo: multiplier being shifted out / quotient being shifted in
    // opnd: multiplicand or divisor
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opnd;
    logic             r_div;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH-1:0] w_hi_src;
    logic [WIDTH-1:0] w_lo_src;
    logic [WIDTH-1:0] w_opnd_src;
    logic             w_div_src;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_hi_next;
    logic [WIDTH-1:0] w_lo_next;
    logic             w_step;

    assign w_step = i_start || ((r_cnt != '0) && (r_cnt != CW'(WIDTH)));
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;
    assign o_done = (r_cnt == CW'(WIDTH));

    // One multiply or divide step, fed either from fresh operands or from the running state
    always_comb begin
        w_hi_src   = r_hi;
        w_lo_src   = r_lo;
        w_opnd_src = r_opnd;
        w_div_src  = r_div;
        if (i_start) begin
            w_hi_src   = '0;
            w_lo_src   = i_div ? i_a : i_b;
            w_opnd_src = i_div ? i_b : i_a;
            w_div_src  = i_div;
        end

        w_mul_sum = {1'b0, w_hi_src} + {1'b0, (w_lo_src[0] ? w_opnd_src : WIDTH'(0))};

        // Partial remainder stays below the divisor, so WIDTH+1 bits hold the shifted value
        // and bit WIDTH of the difference is the borrow.
        w_shift = {w_hi_src, w_lo_src[WIDTH-1]};
        w_diff  = w_shift - {1'b0, w_opnd_src};

        if (w_div_src) begin
            if (!w_diff[WIDTH]) begin
                w_hi_next = w_diff[WIDTH-1:0];
                w_lo_next = {w_lo_src[WIDTH-2:0], 1'b1};
            end else begin
                w_hi_next = w_shift[WIDTH-1:0];
                w_lo_next = {w_lo_src[WIDTH-2:0], 1'b0};
            end
        end else begin
            w_hi_next = w_mul_sum[WIDTH:1];
            w_lo_next = {w_mul_sum[0], w_lo_src[WIDTH-1:1]};
        end
    end

    // Iteration state and step counter; counter parks at WIDTH once finished
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_opnd <= '0;
            r_div  <= 1'b0;
            r_cnt  <= '0;
        end else if (w_step) begin
            r_hi   <= w_hi_next;
            r_lo   <= w_lo_next;
            r_opnd <= w_opnd_src;
            r_div  <= w_div_src;
            r_cnt  <= i_start ? CW'(1) : (r_cnt + CW'(1));
        end
    end

endmodule

// File: rtl/param_calculator.sv
// Four-function unsigned calculator: operands and opcode are entered by
// confirmed presses, ADD/SUB complete in one cycle, MUL/DIV run on the
// iterative unit for exactly WIDTH cycles before results are published.
module param_calculator
    import calc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [WIDTH-1:0] i_in,
    input  logic [1:0]       i_op,
    input  logic             i_confirm,
    input  logic             i_scen,
    output logic [WIDTH-1:0] o_c,
    output logic [WIDTH-1:0] o_r,
    output logic             o_flag,
    output logic             o_err,
    output logic             o_done,
    output logic             o_busy,
    output logic [9:0]       o_q
);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_c;
    logic [WIDTH-1:0] r_r;
    logic             r_flag;

    logic             w_press;
    logic             w_start;
    logic             w_div;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_iter_hi;
    logic [WIDTH-1:0] w_iter_lo;
    logic             w_iter_done;

    assign w_press = i_confirm && i_scen;
    assign w_div   = (i_op == OP_DIV);
    // The unit is launched on the same edge the FSM enters MUL or DIV
    assign w_start = w_press && (r_state == ST_GET_OP) &&
                     ((i_op == OP_MUL) || (w_div && (r_b != '0)));
    assign w_sum   = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff  = r_a - r_b;

    calc_iter_unit #(
        .WIDTH (WIDTH)
    ) u_iter (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_start   (w_start),
        .i_div     (w_div),
        .i_a       (r_a),
        .i_b       (r_b),
        .o_hi      (w_iter_hi),
        .o_lo      (w_iter_lo),
        .o_done    (w_iter_done)
    );

    // Control FSM with operand latches and registered result outputs.
    // The opcode is consumed directly by the GET_OP branch.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_INITIAL;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_r     <= '0;
            r_flag  <= 1'b0;
        end else begin
            case (r_state)
                ST_INITIAL: begin
                    if (w_press) begin
                        r_c     <= '0;
                        r_r     <= '0;
                        r_flag  <= 1'b0;
                        r_state <= ST_GET_A;
                    end
                end
                ST_GET_A: begin
                    if (w_press) begin
                        r_a     <= i_in;
                        r_state <= ST_GET_B;
                    end
                end
                ST_GET_B: begin
                    if (w_press) begin
                        r_b     <= i_in;
                        r_state <= ST_GET_OP;
                    end
                end
                ST_GET_OP: begin
                    if (w_press) begin
                        case (i_op)
                            OP_ADD:  r_state <= ST_ADD;
                            OP_SUB:  r_state <= ST_SUB;
                            OP_MUL:  r_state <= ST_MUL;
                            default: r_state <= (r_b == '0) ? ST_ERR : ST_DIV;
                        endcase
                    end
                end
                ST_ADD: begin
                    r_c     <= w_sum[WIDTH-1:0];
                    r_flag  <= w_sum[WIDTH];
                    r_r     <= '0;
                    r_state <= ST_DONE;
                end
                ST_SUB: begin
                    r_c     <= w_diff;
                    r_flag  <= (r_a < r_b);
                    r_r     <= '0;
                    r_state <= ST_DONE;
                end
                ST_MUL: begin
                    if (w_iter_done) begin
                        r_c     <= w_iter_lo;
                        r_r     <= w_iter_hi;
                        r_flag  <= (w_iter_hi != '0);
                        r_state <= ST_DONE;
                    end
                end
                ST_DIV: begin
                    if (w_iter_done) begin
                        r_c     <= w_iter_lo;
                        r_r     <= w_iter_hi;
                        r_flag  <= 1'b0;
                        r_state <= ST_DONE;
                    end
                end
                ST_ERR, ST_DONE: begin
                    if (w_press) begin
                        r_state <= ST_INITIAL;
                    end
                end
                default: begin
                    r_state <= ST_INITIAL;
                end
            endcase
        end
    end

    assign o_c    = r_c;
    assign o_r    = r_r;
    assign o_flag = r_flag;
    assign o_q    = r_state;
    assign o_err  = r_state[Q_ERR_BIT];
    assign o_done = r_state[Q_DONE_BIT];
    assign o_busy = r_state[Q_MUL_BIT] | r_state[Q_DIV_BIT];

endmodule

// File: tb/tb_param_calculator.sv
// Directed bench for param_calculator: a 16-bit instance exercises every
// operation and control path, an 8-bit instance shares the stimulus and
// is checked on the wide-multiply regression.
module tb_param_calculator;

    localparam logic [9:0] Q_INIT  = 10'h200;
    localparam logic [9:0] Q_GETA  = 10'h100;
    localparam logic [9:0] Q_GETOP = 10'h040;
    localparam logic [9:0] Q_ADD   = 10'h020;
    localparam logic [9:0] Q_ERR   = 10'h002;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        confirm;
    logic        scen;
    logic [1:0]  op;
    logic [15:0] in16;
    logic [7:0]  in8;

    logic [15:0] c16, r16;
    logic        flag16, err16, done16, busy16;
    logic [9:0]  q16;
    logic [7:0]  c8, r8;
    logic        flag8, err8, done8, busy8;
    logic [9:0]  q8;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;
    assign in8 = in16[7:0];

    param_calculator #(.WIDTH(16)) dut16 (
        .i_clk(clk), .i_reset_n(rst_n), .i_in(in16), .i_op(op),
        .i_confirm(confirm), .i_scen(scen),
        .o_c(c16), .o_r(r16), .o_flag(flag16), .o_err(err16),
        .o_done(done16), .o_busy(busy16), .o_q(q16)
    );

    param_calculator #(.WIDTH(8)) dut8 (
        .i_clk(clk), .i_reset_n(rst_n), .i_in(in8), .i_op(op),
        .i_confirm(confirm), .i_scen(scen),
        .o_c(c8), .o_r(r8), .o_flag(flag8), .o_err(err8),
        .o_done(done8), .o_busy(busy8), .o_q(q8)
    );

    // One press spanning exactly one rising edge; returns on the following falling edge
    task automatic press(input logic [15:0] v, input logic [1:0] o);
        @(negedge clk);
        in16 = v; op = o; confirm = 1'b1; scen = 1'b1;
        @(negedge clk);
        confirm = 1'b0; scen = 1'b0;
    endtask

    // From INITIAL: open, enter A, enter B, press opcode
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] o);
        press(16'h0, 2'b00);
        press(a, 2'b00);
        press(b, 2'b00);
        press(16'h0, o);
    endtask

    // Count falling edges with Busy high, bounded
    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy16 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; confirm = 1'b0; scen = 1'b0; op = 2'b00; in16 = 16'h0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (q16 !== Q_INIT) begin n_fail++; $display("FAIL reset_q got %h want %h", q16, Q_INIT); end
        n_tests++;
        if ({c16, r16, flag16} !== 33'h0) begin n_fail++; $display("FAIL reset_data got c=%h r=%h f=%b want 0", c16, r16, flag16); end
        n_tests++;
        if ({done16, err16, busy16} !== 3'b000) begin n_fail++; $display("FAIL reset_status got %b want 000", {done16, err16, busy16}); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (q16 !== Q_INIT) begin n_fail++; $display("FAIL reset_idle got %h want %h", q16, Q_INIT); end
        $display("[TB] reset: q=%h", q16);
    endtask

    task automatic test_add;
        press(16'h0, 2'b00);
        n_tests++;
        if (q16 !== Q_GETA) begin n_fail++; $display("FAIL add_geta got %h want %h", q16, Q_GETA); end
        press(16'h0003, 2'b00);
        press(16'h0004, 2'b00);
        press(16'h0, 2'b00);
        n_tests++;
        if (q16 !== Q_ADD || done16 !== 1'b0) begin n_fail++; $display("FAIL add_lat1 got q=%h done=%b want q=%h done=0", q16, done16, Q_ADD); end
        @(negedge clk);
        n_tests++;
        if (done16 !== 1'b1) begin n_fail++; $display("FAIL add_lat2 got done=%b want 1", done16); end
        n_tests++;
        if (c16 !== 16'h0007 || r16 !== 16'h0 || flag16 !== 1'b0) begin n_fail++; $display("FAIL add_res got c=%h r=%h f=%b want 0007 0000 0", c16, r16, flag16); end
        $display("[TB] ADD 0003+0004 -> c=%h r=%h f=%b", c16, r16, flag16);
        press(16'h0, 2'b00);
        n_tests++;
        if (q16 !== Q_INIT) begin n_fail++; $display("FAIL add_back got %h want %h", q16, Q_INIT); end
    endtask

    task automatic test_add_overflow;
        run_op(16'hFFFF, 16'h0001, 2'b00);
        @(negedge clk);
        n_tests++;
        if (c16 !== 16'h0000 || flag16 !== 1'b1 || done16 !== 1'b1) begin n_fail++; $display("FAIL add_ovf got c=%h f=%b done=%b want 0000 1 1", c16, flag16, done16); end
        $display("[TB] ADD FFFF+0001 -> c=%h f=%b", c16, flag16);
        press(16'h0, 2'b00);
    endtask

    task automatic test_sub;
        run_op(16'h0002, 16'h0005, 2'b01);
        @(negedge clk);
        n_tests++;
        if (c16 !== 16'hFFFD || flag16 !== 1'b1 || r16 !== 16'h0) begin n_fail++; $display("FAIL sub_borrow got c=%h r=%h f=%b want FFFD 0000 1", c16, r16, flag16); end
        $display("[TB] SUB 0002-0005 -> c=%h f=%b", c16, flag16);
        press(16'h0, 2'b00);
    endtask

    task automatic test_mul;
        int cnt;
        run_op(16'h1234, 16'h0100, 2'b10);
        count_busy(cnt);
        n_tests++;
        if (cnt !== 16) begin n_fail++; $display("FAIL mul_busy got %0d cycles want 16", cnt); end
        n_tests++;
        if (done16 !== 1'b1) begin n_fail++; $display("FAIL mul_done got %b want 1", done16); end
        n_tests++;
        if (c16 !== 16'h3400 || r16 !== 16'h0012 || flag16 !== 1'b1) begin n_fail++; $display("FAIL mul_res got c=%h r=%h f=%b want 3400 0012 1", c16, r16, flag16); end
        $display("[TB] MUL 1234*0100 -> c=%h r=%h f=%b busy=%0d", c16, r16, flag16, cnt);
        press(16'h0, 2'b00);
    endtask

    task automatic test_div;
        int cnt;
        run_op(16'h0064, 16'h0007, 2'b11);
        count_busy(cnt);
        n_tests++;
        if (cnt !== 16) begin n_fail++; $display("FAIL div_busy got %0d cycles want 16", cnt); end
        n_tests++;
        if (c16 !== 16'h000E || r16 !== 16'h0002 || flag16 !== 1'b0 || done16 !== 1'b1) begin n_fail++; $display("FAIL div_res got c=%h r=%h f=%b done=%b want 000E 0002 0 1", c16, r16, flag16, done16); end
        $display("[TB] DIV 0064/0007 -> c=%h r=%h f=%b", c16, r16, flag16);
        press(16'h0, 2'b00);
    endtask

    task automatic test_div_by_zero;
        run_op(16'h0005, 16'h0000, 2'b11);
        n_tests++;
        if (q16 !== Q_ERR || err16 !== 1'b1 || busy16 !== 1'b0) begin n_fail++; $display("FAIL div0_err got q=%h err=%b busy=%b want %h 1 0", q16, err16, busy16, Q_ERR); end
        repeat (3) @(negedge clk);
        n_tests++;
        if (q16 !== Q_ERR || c16 !== 16'h0 || r16 !== 16'h0) begin n_fail++; $display("FAIL div0_hold got q=%h c=%h r=%h want %h 0000 0000", q16, c16, r16, Q_ERR); end
        $display("[TB] DIV 0005/0000 -> q=%h err=%b", q16, err16);
        press(16'h0, 2'b00);
        n_tests++;
        if (q16 !== Q_INIT || err16 !== 1'b0) begin n_fail++; $display("FAIL div0_exit got q=%h err=%b want %h 0", q16, err16, Q_INIT); end
    endtask

    task automatic test_edges;
        int cnt;
        run_op(16'h0003, 16'h0009, 2'b11);
        count_busy(cnt);
        n_tests++;
        if (c16 !== 16'h0000 || r16 !== 16'h0003 || done16 !== 1'b1) begin n_fail++; $display("FAIL div_small got c=%h r=%h done=%b want 0000 0003 1", c16, r16, done16); end
        $display("[TB] DIV 0003/0009 -> c=%h r=%h", c16, r16);
        press(16'h0, 2'b00);
        run_op(16'h1234, 16'h0000, 2'b10);
        count_busy(cnt);
        n_tests++;
        if (c16 !== 16'h0 || r16 !== 16'h0 || flag16 !== 1'b0 || done16 !== 1'b1) begin n_fail++; $display("FAIL mul_zero got c=%h r=%h f=%b done=%b want 0000 0000 0 1", c16, r16, flag16, done16); end
        $display("[TB] MUL 1234*0000 -> c=%h r=%h f=%b", c16, r16, flag16);
        press(16'h0, 2'b00);
    endtask

    task automatic test_reset_mid_mul;
        run_op(16'h1234, 16'h0100, 2'b10);
        repeat (7) @(negedge clk);
        n_tests++;
        if (busy16 !== 1'b1) begin n_fail++; $display("FAIL rstmul_busy got %b want 1", busy16); end
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if (q16 !== Q_INIT) begin n_fail++; $display("FAIL rstmul_q got %h want %h", q16, Q_INIT); end
        n_tests++;
        if ({c16, r16, flag16, done16, err16, busy16} !== 35'h0) begin n_fail++; $display("FAIL rstmul_out got c=%h r=%h f=%b d=%b e=%b b=%b want 0", c16, r16, flag16, done16, err16, busy16); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        n_tests++;
        if (q16 !== Q_INIT || done16 !== 1'b0) begin n_fail++; $display("FAIL rstmul_wait got q=%h done=%b want %h 0", q16, done16, Q_INIT); end
        $display("[TB] reset mid-MUL -> q=%h", q16);
    endtask

    task automatic test_scen_gate;
        int bad = 0;
        press(16'h0, 2'b00);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in16 = 16'(i * 16'h1111); confirm = 1'b1; scen = 1'b0;
            if (q16 !== Q_GETA) bad++;
        end
        @(negedge clk);
        confirm = 1'b0;
        n_tests++;
        if (q16 !== Q_GETA || bad != 0) begin n_fail++; $display("FAIL scen_gate got q=%h bad=%0d want %h 0", q16, bad, Q_GETA); end
        press(16'h0007, 2'b00);
        press(16'h0008, 2'b00);
        n_tests++;
        if (q16 !== Q_GETOP) begin n_fail++; $display("FAIL scen_getop got %h want %h", q16, Q_GETOP); end
        press(16'h0, 2'b00);
        @(negedge clk);
        n_tests++;
        if (c16 !== 16'h000F || done16 !== 1'b1) begin n_fail++; $display("FAIL scen_add got c=%h done=%b want 000F 1", c16, done16); end
        $display("[TB] gated confirm then ADD 0007+0008 -> c=%h", c16);
        press(16'h0, 2'b00);
    endtask

    task automatic test_w8_mul;
        int cnt8 = 0;
        int wait16 = 0;
        run_op(16'h00FF, 16'h00FF, 2'b10);
        while (busy8 && cnt8 < 100) begin
            cnt8++;
            @(negedge clk);
        end
        n_tests++;
        if (cnt8 !== 8) begin n_fail++; $display("FAIL w8_busy got %0d cycles want 8", cnt8); end
        n_tests++;
        if (c8 !== 8'h01 || r8 !== 8'hFE || flag8 !== 1'b1 || done8 !== 1'b1) begin n_fail++; $display("FAIL w8_mul got c=%h r=%h f=%b done=%b want 01 FE 1 1", c8, r8, flag8, done8); end
        $display("[TB] W8 MUL FF*FF -> c=%h r=%h f=%b", c8, r8, flag8);
        while (!done16 && wait16 < 100) begin
            wait16++;
            @(negedge clk);
        end
        n_tests++;
        if (c16 !== 16'hFE01 || r16 !== 16'h0 || flag16 !== 1'b0) begin n_fail++; $display("FAIL w16_mul got c=%h r=%h f=%b want FE01 0000 0", c16, r16, flag16); end
        press(16'h0, 2'b00);
    endtask

    initial begin
        test_reset();
        test_add();
        test_add_overflow();
        test_sub();
        test_mul();
        test_div();
        test_div_by_zero();
        test_edges();
        test_reset_mid_mul();
        test_scen_gate();
        test_w8_mul();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
